// File: rtl/ysyx_22040895_idu_buf.sv
// Buffered decode stage: instruction FIFO feeding a registered decoder with
// valid/ready handshakes on both sides and a redirect flush.
module ysyx_22040895_idu_buf #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 4,
  parameter int CSR_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          inst_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           opcode_o,
  output logic [2:0]           func3_o,
  output logic [6:0]           func7_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [XLEN-1:0]      imm_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [CSR_IDX_W-1:0] csr_idx_o,
  output logic                 illegal_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, head_valid;

  assign in_ready   = (count < FULL);
  assign head_valid = (count != '0);
  assign push       = in_valid & in_ready;
  assign pop        = head_valid & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr] <= inst_i;
      pc_mem[wr_ptr]   <= pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  logic [31:0]          head;
  logic [6:0]           raw_op;
  logic [6:0]           op_d;
  logic [XLEN-1:0]      imm_d;
  logic [CSR_IDX_W-1:0] csr_d;
  logic                 ill_d;

  assign head   = inst_mem[rd_ptr];
  assign raw_op = head[6:0];

  always_comb begin
    op_d = raw_op;
    if (head == 32'h0000_0073)      op_d = 7'h7F;
    else if (head == 32'h3020_0073) op_d = 7'h7E;
  end

  // Immediate format follows the raw opcode field, before ecall/mret remapping.
  always_comb begin
    imm_d = '0;
    case (raw_op)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32, OP_SYSTEM:
        imm_d = {{(XLEN-12){head[31]}}, head[31:20]};
      OP_STORE:
        imm_d = {{(XLEN-12){head[31]}}, head[31:25], head[11:7]};
      OP_BRANCH:
        imm_d = {{(XLEN-13){head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_d = {{(XLEN-32){head[31]}}, head[31:12], 12'b0};
      OP_JAL:
        imm_d = {{(XLEN-21){head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
  end

  always_comb begin
    csr_d = '0;
    ill_d = 1'b0;
    if (raw_op == OP_SYSTEM && head[14:12] != 3'b000) begin
      case (head[31:20])
        12'h341: csr_d = CSR_IDX_W'(0);
        12'h342: csr_d = CSR_IDX_W'(1);
        12'h305: csr_d = CSR_IDX_W'(2);
        12'h300: csr_d = CSR_IDX_W'(3);
        default: begin
          csr_d = '1;
          ill_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      opcode_o  <= '0;
      func3_o   <= '0;
      func7_o   <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      rd_o      <= '0;
      imm_o     <= '0;
      pc_o      <= '0;
      csr_idx_o <= '0;
      illegal_o <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      opcode_o  <= op_d;
      func3_o   <= head[14:12];
      func7_o   <= head[31:25];
      rs1_o     <= head[19:15];
      rs2_o     <= head[24:20];
      rd_o      <= head[11:7];
      imm_o     <= imm_d;
      pc_o      <= pc_mem[rd_ptr];
      csr_idx_o <= csr_d;
      illegal_o <= ill_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
